sha3_scan_request_loader: RTL and testbench

- Upstream producer for the SHA3 scanner request bus.
- Accepts a 32-bit word stream (26-word frames: 24 block-template words, then threshold low, then threshold high) into a staging bank.
- On a complete frame, commits the frame atomically and issues a single-cycle start when the scanner is idle.
- Optionally re-dispatches the same template with an advanced start nonce (word [20]) when the scanner reports range exhausted.

---
 rtl/sha3_scan_request_loader_if.sv | 8 +
 rtl/sha3_scan_request_loader.sv | 80 ++++++++
 tb/tb_sha3_scan_request_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sha3_scan_request_loader_if.sv
// i_sha3_scan_request_bus: start strobe plus block template and threshold for the SHA3 scanner
interface i_sha3_scan_request_bus;
    logic              start;
    logic [23:0][31:0] blockTemplate;
    logic [63:0]       threshold;
    modport producer (output start, blockTemplate, threshold);
    modport consumer (input start, blockTemplate, threshold);
endinterface

// File: rtl/sha3_scan_request_loader.sv
// sha3_scan_request_loader: stages 26-word frames, commits atomically and dispatches scanner starts
module sha3_scan_request_loader #(
    parameter bit          AUTO_ADVANCE = 1'b1,
    parameter logic [31:0] NONCE_STRIDE = 32'h0001_0000,
    parameter int          COUNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic                    scanner_busy,
    input  logic                    scanner_done,
    i_sha3_scan_request_bus.producer req,
    output logic                    frame_error,
    output logic                    nonce_wrapped,
    output logic [COUNT_W-1:0]      dispatch_count
);
    localparam logic [0:0] LOAD  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    logic [0:0]  state;
    logic [4:0]  idx;
    logic [31:0] staging [25];
    logic        pending;
    logic [1:0]  guard;
    logic        accept, commit, dispatch, advance;
    logic [32:0] sum;
    always_comb begin
        accept   = in_valid && in_ready;
        commit   = accept && state == LOAD && idx == 5'd25 && in_last;
        dispatch = pending && !scanner_busy && guard == 2'd0;
        sum      = {1'b0, req.blockTemplate[20]} + {1'b0, NONCE_STRIDE};
        advance  = AUTO_ADVANCE && scanner_done && !commit;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= LOAD;
            idx               <= '0;
            for (int i = 0; i < 25; i++) staging[i] <= '0;
            pending           <= 1'b0;
            guard             <= '0;
            in_ready          <= 1'b0;
            frame_error       <= 1'b0;
            nonce_wrapped     <= 1'b0;
            dispatch_count    <= '0;
            req.start         <= 1'b0;
            req.blockTemplate <= '0;
            req.threshold     <= '0;
        end else begin
            in_ready      <= 1'b1;
            frame_error   <= 1'b0;
            nonce_wrapped <= advance && sum[32];
            req.start     <= dispatch;
            // guard hides the scanner's busy-rise latency after each start
            guard         <= dispatch ? 2'd2 : guard - {1'b0, guard != 2'd0};
            if (dispatch) begin
                pending        <= 1'b0;
                dispatch_count <= dispatch_count + COUNT_W'(1);
            end
            if (accept && state == DRAIN) begin
                if (in_last) state <= LOAD;
            end else if (accept) begin
                if (idx != 5'd25) staging[idx] <= in_data;
                idx         <= (in_last || idx == 5'd25) ? 5'd0 : idx + 5'd1;
                frame_error <= (idx == 5'd25) != in_last;
                if (idx == 5'd25 && !in_last) state <= DRAIN;
            end
            if (advance && !sum[32]) begin
                req.blockTemplate[20] <= sum[31:0];
                pending               <= 1'b1;
            end
            if (commit) begin
                for (int i = 0; i < 24; i++) req.blockTemplate[i] <= staging[i];
                req.threshold <= {in_data, staging[24]};
                pending       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha3_scan_request_loader.sv
// tb_sha3_scan_request_loader: frame-level reference model plus directed scenarios
module tb_sha3_scan_request_loader;
    localparam logic [31:0] STRIDE = 32'h0001_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic        busy = 1'b0, done = 1'b0;
    logic        frame_error, nonce_wrapped;
    logic [15:0] dispatch_count;
    int          checks = 0, failures = 0;

    i_sha3_scan_request_bus bus ();

    sha3_scan_request_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .scanner_busy(busy), .scanner_done(done), .req(bus),
        .frame_error(frame_error), .nonce_wrapped(nonce_wrapped), .dispatch_count(dispatch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: collects words into a frame and judges it when the frame ends
    logic [31:0]       mq [$];
    bit                m_bad = 0, m_pend = 0, m_start = 0, m_ferr = 0, m_wrap = 0, m_rdy = 0;
    logic [23:0][31:0] m_bt = '0;
    logic [63:0]       m_th = '0;
    int                m_cool = 0;
    logic [15:0]       m_cnt = '0;
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete(); m_bad = 0; m_pend = 0; m_start = 0; m_ferr = 0; m_wrap = 0; m_rdy = 0;
            m_bt = '0; m_th = '0; m_cool = 0; m_cnt = '0;
        end else begin : step
            bit go, com;
            go = m_pend && !busy && m_cool == 0;
            com = 0;
            m_ferr = 0;
            m_wrap = 0;
            if (in_valid && m_rdy) begin
                if (m_bad) m_bad = !in_last;
                else begin
                    mq.push_back(in_data);
                    if (in_last || mq.size() == 26) begin
                        com = in_last && mq.size() == 26;
                        m_ferr = !com;
                        m_bad = !in_last;
                        if (com) begin
                            for (int i = 0; i < 24; i++) m_bt[i] = mq[i];
                            m_th = {mq[25], mq[24]};
                        end
                        mq.delete();
                    end
                end
            end
            if (go) begin m_pend = 0; m_cnt++; m_cool = 2; end
            else if (m_cool > 0) m_cool--;
            if (done && !com) begin
                if (m_bt[20] > 32'hFFFF_FFFF - STRIDE) m_wrap = 1;
                else begin m_bt[20] = m_bt[20] + STRIDE; m_pend = 1; end
            end
            if (com) m_pend = 1;
            m_start = go;
            m_rdy = 1;
        end
    end

    always @(negedge clk) begin
        chk("start", bus.start, m_start);
        chk("template", bus.blockTemplate, m_bt);
        chk("threshold", bus.threshold, m_th);
        chk("frame_error", frame_error, m_ferr);
        chk("nonce_wrapped", nonce_wrapped, m_wrap);
        chk("dispatch_count", dispatch_count, m_cnt);
        chk("in_ready", in_ready, m_rdy);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        in_data = d; in_valid = 1'b1; in_last = l;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [31:0] w20,
                              input logic [31:0] w24, input logic [31:0] w25, input logic dl);
        for (int i = 0; i < 24; i++) send_word(i == 20 ? w20 : base + i, 1'b0);
        send_word(w24, 1'b0);
        done = dl;
        send_word(w25, 1'b1);
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        // basic frame and N+2 start latency
        send_frame(32'h0, 32'd20, 32'h10, 32'h0, 1'b0);
        chk("t1_start_n1", bus.start, 1'b0);
        tick();
        chk("t1_start_n2", bus.start, 1'b1);
        tick();
        chk("t1_start_n3", bus.start, 1'b0);
        chk("t1_bt5", bus.blockTemplate[5], 32'd5);
        chk("t1_bt23", bus.blockTemplate[23], 32'd23);
        chk("t1_th", bus.threshold, 64'h10);
        chk("t1_cnt", dispatch_count, 16'd1);
        // early in_last
        for (int i = 0; i <= 10; i++) send_word(32'h900 + i, i == 10);
        chk("t2_ferr", frame_error, 1'b1);
        send_frame(32'h100, 32'h120, 32'h11, 32'h22, 1'b0);
        repeat (3) tick();
        chk("t2_bt0", bus.blockTemplate[0], 32'h100);
        chk("t2_cnt", dispatch_count, 16'd2);
        // missing in_last then drain
        for (int i = 0; i < 26; i++) send_word(32'h50 + i, 1'b0);
        chk("t3_ferr", frame_error, 1'b1);
        chk("t3_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + i, i == 2);
        chk("t3_no_commit", bus.blockTemplate[0], 32'h100);
        send_frame(32'h300, 32'h320, 32'hAA, 32'hBB, 1'b0);
        repeat (3) tick();
        chk("t3_th", bus.threshold, 64'h0000_00BB_0000_00AA);
        chk("t3_cnt", dispatch_count, 16'd3);
        // busy holds off the start; latest frame wins
        busy = 1'b1;
        send_frame(32'h400, 32'h420, 32'h1, 32'h2, 1'b0);
        send_frame(32'h500, 32'h520, 32'h3, 32'h4, 1'b0);
        repeat (3) tick();
        busy = 1'b0;
        tick();
        chk("t4_start", bus.start, 1'b1);
        chk("t4_bt0", bus.blockTemplate[0], 32'h500);
        chk("t4_th", bus.threshold, 64'h0000_0004_0000_0003);
        tick();
        chk("t4_cnt", dispatch_count, 16'd4);
        // auto-advance
        send_frame(32'h600, 32'h0, 32'h5, 32'h6, 1'b0);
        repeat (4) tick();
        done = 1'b1; tick(); done = 1'b0;
        chk("t5_bt20", bus.blockTemplate[20], 32'h0001_0000);
        tick();
        chk("t5_restart", bus.start, 1'b1);
        chk("t5_cnt", dispatch_count, 16'd6);
        send_frame(32'h700, 32'hFFFF_0000, 32'h7, 32'h8, 1'b0);
        repeat (4) tick();
        done = 1'b1; tick(); done = 1'b0;
        chk("t5_wrap", nonce_wrapped, 1'b1);
        chk("t5_wrap_bt20", bus.blockTemplate[20], 32'hFFFF_0000);
        tick();
        chk("t5_wrap_nostart", bus.start, 1'b0);
        chk("t5_wrap_cnt", dispatch_count, 16'd7);
        send_frame(32'h800, 32'h5, 32'h9, 32'hA, 1'b1);
        chk("t5_commit_wins", bus.blockTemplate[20], 32'h5);
        repeat (3) tick();
        chk("t5_cnt2", dispatch_count, 16'd8);
        // reset mid-frame with a pending start
        busy = 1'b1;
        send_frame(32'hA00, 32'hA20, 32'hB, 32'hC, 1'b0);
        for (int i = 0; i < 12; i++) send_word(32'hB00 + i, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_bt", bus.blockTemplate, '0);
        chk("t6_rst_th", bus.threshold, 64'h0);
        chk("t6_rst_cnt", dispatch_count, 16'd0);
        chk("t6_rst_ready", in_ready, 1'b0);
        busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_ready_low", in_ready, 1'b0);
        tick();
        chk("t6_ready_high", in_ready, 1'b1);
        repeat (5) tick();
        chk("t6_nostart", bus.start, 1'b0);
        chk("t6_cnt", dispatch_count, 16'd0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
